dmem_responder: RTL and testbench

Data-memory responder for the pipelined MIPS core: the memory-side end of the load/store request interface driven by the MEM stage. Accepts one request at a time through a valid/ready handshake. Applies a parameterised number of wait states, then performs a word read or a byte-enabled write on an internal word-addressed array. Returns data and an error flag with a one-cycle response pulse.

---
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, WAIT_CYCLES wait states, word read or store, one-cycle response pulse.
// Optional feature macro: DMEM_BYTE_WRITE_EN (per-byte store enables; otherwise every store writes the full word).
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic                lat_write;
   logic [31:0]         lat_addr;
   logic [3:0]          lat_be;
   logic [31:0]         lat_wdata;

   logic [31:0]            mem [DEPTH];
   logic                   addr_err_c;
   logic [ADDR_WIDTH-1:0]  word_idx_c;
   logic                   commit_c;
   logic [3:0]             be_eff_c;
   logic [31:0]            merged_c;

   // Decode of the latched request; commit happens on the last WAIT cycle
   always_comb begin
      addr_err_c = (lat_addr[1:0] != 2'b00) || ((lat_addr >> (ADDR_WIDTH + 2)) != 32'd0);
      word_idx_c = lat_addr[ADDR_WIDTH+1:2];
      commit_c   = (state == WAIT) && (cnt == '0);
   end

   // Store data merged with the current word under the effective byte enables
   always_comb begin
`ifdef DMEM_BYTE_WRITE_EN
      be_eff_c = lat_be;
`else
      be_eff_c = lat_be | 4'hF;
`endif
      merged_c = mem[word_idx_c];
      for (int i = 0; i < 4; i++) begin
         if (be_eff_c[i]) begin
            merged_c[8*i +: 8] = lat_wdata[8*i +: 8];
         end
      end
   end

   // Array is deliberately not reset; writes are gated by the reset-cleared FSM state
   always_ff @(posedge clk) begin
      if (commit_c && lat_write && !addr_err_c) begin
         mem[word_idx_c] <= merged_c;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         lat_write  <= 1'b0;
         lat_addr   <= 32'd0;
         lat_be     <= 4'h0;
         lat_wdata  <= 32'd0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_be    <= req_be;
                  lat_wdata <= req_wdata;
                  cnt       <= CNT_W'(WAIT_CYCLES);
                  req_ready <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  resp_valid <= 1'b1;
                  resp_err   <= addr_err_c;
                  resp_rdata <= (lat_write || addr_err_c) ? 32'd0 : mem[word_idx_c];
                  state      <= RESP;
               end
            end
            RESP: begin
               resp_rdata <= 32'd0;
               resp_err   <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array reference model.
// A second instance with WAIT_CYCLES=0 covers back-to-back cadence.
`timescale 1ns/1ps
module tb_dmem_responder;

   localparam int unsigned AW = 10;
   localparam int unsigned WC = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req_valid, req_ready, req_write, resp_valid, resp_err;
   logic [31:0] req_addr, req_wdata, resp_rdata;
   logic [3:0]  req_be;

   logic        b_valid, b_ready, b_write, b_resp_valid, b_resp_err;
   logic [31:0] b_addr, b_wdata, b_resp_rdata;
   logic [3:0]  b_be;

   int n_checks = 0;
   int n_errors = 0;
   int b_pulses = 0;
   int b_err_pulses = 0;
   logic [31:0] model [int];
   int acc[$];

   dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut_fast (
      .clk(clk), .reset(reset),
      .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
      .req_addr(b_addr), .req_be(b_be), .req_wdata(b_wdata),
      .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= 32'(4 << AW));
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] m;
      m = 32'hFFFF_FFFF;
`ifdef DMEM_BYTE_WRITE_EN
      for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
`endif
      return (old & ~m) | (d & m);
   endfunction

   // One full request on the WAIT_CYCLES=2 instance, checked against the model
   task automatic xact(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input string tag);
      int lat;
      int idx;
      logic exp_err;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_be = be; req_wdata = wd;
      for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
      check({tag, "_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      req_write = 1'($urandom);
      check({tag, "_busy"}, 32'(req_ready), 32'd0);
      lat = 0;
      while (!resp_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(WC + 1));
      exp_err = addr_bad(addr);
      idx = int'(addr[AW+1:2]);
      if (!exp_err && wr) model[idx] = merge(model.exists(idx) ? model[idx] : 32'd0, wd, be);
      check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
      if (wr || exp_err) check({tag, "_rdata"}, resp_rdata, 32'd0);
      else if (model.exists(idx)) check({tag, "_rdata"}, resp_rdata, model[idx]);
      @(posedge clk);
      #1;
      check({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
      check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_rdata_clr"}, resp_rdata, 32'd0);
   endtask

   always @(posedge clk) begin
      if (reset && b_resp_valid) begin
         b_pulses++;
         if (b_resp_err) b_err_pulses++;
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic seen;
      logic [31:0] a;
      int kind;
      reset = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_be = 4'h0; req_wdata = 32'd0;
      b_valid = 1'b0; b_write = 1'b0; b_addr = 32'd0; b_be = 4'h0; b_wdata = 32'd0;

      // Reset held for three cycles, then idle
      repeat (3) begin
         @(negedge clk);
         check("rst_ready", 32'(req_ready), 32'd1);
         check("rst_valid", 32'(resp_valid), 32'd0);
         check("rst_rdata", resp_rdata, 32'd0);
      end
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_ready", 32'(req_ready), 32'd1);
         check("idle_valid", 32'(resp_valid), 32'd0);
         check("idle_rdata", resp_rdata, 32'd0);
      end

      // Word round trip
      xact(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "rt_st");
      xact(1'b0, 32'h10, 4'hF, 32'h0, "rt_ld");
      check("rt_model", model[4], 32'hDEADBEEF);

      // Byte enables
      xact(1'b1, 32'h20, 4'hF, 32'h11223344, "be_pre");
      xact(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, "be_st");
      xact(1'b0, 32'h20, 4'h0, 32'h0, "be_ld");
`ifdef DMEM_BYTE_WRITE_EN
      check("be_const", model[8], 32'h11BB33DD);
`else
      check("be_const", model[8], 32'hAABBCCDD);
`endif
      xact(1'b1, 32'h20, 4'h0, 32'h01020304, "be_zero");
      xact(1'b0, 32'h20, 4'h0, 32'h0, "be_zero_ld");

      // Error cases leave the array untouched
      xact(1'b1, 32'h0, 4'hF, 32'hCAFEF00D, "err_pre");
      xact(1'b0, 32'h2, 4'hF, 32'h0, "err_misal");
      xact(1'b1, 32'h1000, 4'hF, 32'h0BADBAD0, "err_range");
      xact(1'b1, 32'h8000_0000, 4'hF, 32'h0BADBAD1, "err_high");
      xact(1'b1, 32'h1, 4'hF, 32'h0BADBAD2, "err_misal_st");
      xact(1'b0, 32'h0, 4'hF, 32'h0, "err_chk0");

      // Reset during WAIT aborts a store without a response
      xact(1'b1, 32'h40, 4'hF, 32'h12345678, "abort_pre");
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_be = 4'hF; req_wdata = 32'h55;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      seen = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) begin
         @(negedge clk);
         seen |= resp_valid;
         check("abort_rst_ready", 32'(req_ready), 32'd1);
      end
      reset = 1'b1;
      repeat (6) begin
         @(negedge clk);
         seen |= resp_valid;
      end
      check("abort_no_resp", 32'(seen), 32'd0);
      xact(1'b0, 32'h40, 4'hF, 32'h0, "abort_ld");

      // Randomized traffic over a small window plus error addresses
      for (int n = 0; n < 60; n++) begin
         kind = int'($urandom_range(0, 9));
         a = {25'd0, 3'($urandom), 2'b00} + 32'h100;
         if (kind == 0) a = a | 32'(($urandom_range(1, 3)));
         else if (kind == 1) a = 32'h1000 + {$urandom, 2'b00};
         xact(1'($urandom), a, 4'($urandom), $urandom, "rand");
      end

      // Back-to-back loads on the zero-wait instance
      b_pulses = 0;
      b_err_pulses = 0;
      @(negedge clk);
      b_valid = 1'b1; b_write = 1'b0; b_addr = 32'h0; b_be = 4'hF;
      for (int cyc = 0; cyc < 60 && acc.size() < 4; cyc++) begin
         if (b_ready) acc.push_back(cyc);
         @(posedge clk);
         #1;
         if (acc.size() > 0 && acc[acc.size()-1] == cyc) b_addr = b_addr + 32'd4;
         if (acc.size() == 4) b_valid = 1'b0;
         @(negedge clk);
      end
      b_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("b2b_count", 32'(acc.size()), 32'd4);
      for (int i = 1; i < acc.size(); i++) check("b2b_gap", 32'(acc[i] - acc[i-1]), 32'd3);
      check("b2b_pulses", 32'(b_pulses), 32'd4);
      check("b2b_err", 32'(b_err_pulses), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
